// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants for the ALU/autoencoder datapath muxes
//
// Purpose: mode selectors for mux_n_1_reg.
//   MODE_SEL : grant follows the external sel input
//   MODE_RR  : grant comes from a round-robin arbiter
package alu_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Purpose: picks the first requesting channel, searching upward from ptr+1
// modulo N_IN. No request means an all-zero one-hot grant.
// Ports:
//   req     in  N_IN   request vector (one bit per channel)
//   ptr     in  SEL_W  index of the most recently granted channel
//   gnt_oh  out N_IN   one-hot grant, zero when nothing is requested
//   gnt_idx out SEL_W  binary index of the granted channel (0 when no grant)
module rr_pick #(
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_IN-1:0]  gnt_oh,
    output logic [SEL_W-1:0] gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        // k runs 1..N_IN so the channel at ptr itself is visited last
        for (int k = 1; k <= N_IN; k++) begin
            idx = (int'(ptr) + k) % N_IN;
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_n_1_reg.sv
// rtl/mux_n_1_reg.sv - registered N:1 stream mux with select or round-robin grant
//
// Purpose: steers one of N_IN valid/ready operand streams into a single
// registered output stage. The grant comes from sel (MODE_SEL) or from a
// round-robin arbiter (MODE_RR).
// Ports:
//   clk        in  1           rising-edge clock
//   rst        in  1           synchronous active-high reset
//   in_data    in  N_IN*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   in  N_IN        per-channel valid
//   in_ready   out N_IN        per-channel ready, at most one bit high
//   sel        in  SEL_W       channel select (MODE_SEL only)
//   out_data   out WIDTH       registered output word
//   out_valid  out 1           output word valid
//   out_ready  in  1           downstream accepts the word
//   out_src    out SEL_W       channel that produced out_data
module mux_n_1_reg
    import alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int N_IN  = 4,
    parameter  int MODE  = MODE_SEL,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_src
);

    logic             can_load;
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             transfer;

    // Output register is free when empty or being drained this cycle;
    // this is the only combinational path from out_ready to in_ready.
    assign can_load = !out_valid || out_ready;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] ptr;
            logic [N_IN-1:0]  gnt_oh;

            rr_pick #(
                .N_IN  (N_IN),
                .SEL_W (SEL_W)
            ) u_rr_pick (
                .req     (in_valid),
                .ptr     (ptr),
                .gnt_oh  (gnt_oh),
                .gnt_idx (gnt_idx)
            );

            assign gnt_valid = |gnt_oh;

            // Pointer moves only on a real transfer, so a stalled or idle
            // cycle never costs a channel its turn.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ptr <= SEL_W'(N_IN - 1);
                end else if (transfer) begin
                    ptr <= gnt_idx;
                end
            end
        end else begin : g_sel
            localparam logic [SEL_W:0] N_IN_L = (SEL_W + 1)'(N_IN);

            // sel values past the last channel (non-power-of-two N_IN) grant nothing
            assign gnt_valid = ({1'b0, sel} < N_IN_L);
            assign gnt_idx   = sel;
        end
    endgenerate

    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_data    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = gnt_valid && can_load && !rst;
            end
        end
    end

    assign transfer = |(in_valid & in_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_src   <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_n_1_reg.sv
// tb/tb_mux_n_1_reg.sv - directed self-checking bench for mux_n_1_reg
module tb_mux_n_1_reg;

    logic clk;
    logic rst;

    // MODE_SEL, N_IN=4
    logic [63:0] s4_in_data;
    logic [3:0]  s4_in_valid, s4_in_ready;
    logic [1:0]  s4_sel, s4_out_src;
    logic [15:0] s4_out_data;
    logic        s4_out_valid, s4_out_ready;

    // MODE_SEL, N_IN=5
    logic [79:0] s5_in_data;
    logic [4:0]  s5_in_valid, s5_in_ready;
    logic [2:0]  s5_sel, s5_out_src;
    logic [15:0] s5_out_data;
    logic        s5_out_valid, s5_out_ready;

    // MODE_RR, N_IN=4
    logic [63:0] rr_in_data;
    logic [3:0]  rr_in_valid, rr_in_ready;
    logic [1:0]  rr_sel, rr_out_src;
    logic [15:0] rr_out_data;
    logic        rr_out_valid, rr_out_ready;

    int checks;
    int errors;

    mux_n_1_reg #(.WIDTH(16), .N_IN(4), .MODE(0)) dut_s4 (
        .clk(clk), .rst(rst), .in_data(s4_in_data), .in_valid(s4_in_valid),
        .in_ready(s4_in_ready), .sel(s4_sel), .out_data(s4_out_data),
        .out_valid(s4_out_valid), .out_ready(s4_out_ready), .out_src(s4_out_src)
    );

    mux_n_1_reg #(.WIDTH(16), .N_IN(5), .MODE(0)) dut_s5 (
        .clk(clk), .rst(rst), .in_data(s5_in_data), .in_valid(s5_in_valid),
        .in_ready(s5_in_ready), .sel(s5_sel), .out_data(s5_out_data),
        .out_valid(s5_out_valid), .out_ready(s5_out_ready), .out_src(s5_out_src)
    );

    mux_n_1_reg #(.WIDTH(16), .N_IN(4), .MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .in_data(rr_in_data), .in_valid(rr_in_valid),
        .in_ready(rr_in_ready), .sel(rr_sel), .out_data(rr_out_data),
        .out_valid(rr_out_valid), .out_ready(rr_out_ready), .out_src(rr_out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        s4_in_valid = 4'hF;  s5_in_valid = 5'h1F;  rr_in_valid = 4'hF;
        s4_out_ready = 1'b1; s5_out_ready = 1'b1;  rr_out_ready = 1'b1;
        s4_sel = 2'd0; s5_sel = 3'd0; rr_sel = 2'd0;
        s4_in_data = 64'h0003_0002_0001_0000;
        s5_in_data = 80'h0004_0003_0002_0001_0000;
        rr_in_data = 64'h1003_1002_1001_1000;
        rst = 1'b1;
        step();
        step();
        checks++;
        if (s4_out_valid !== 1'b0 || s4_out_data !== 16'h0 || s4_out_src !== 2'd0) begin
            errors++;
            $display("FAIL reset_s4_out: valid=%b data=%h src=%0d, required 0/0000/0", s4_out_valid, s4_out_data, s4_out_src);
        end
        checks++;
        if (rr_out_valid !== 1'b0 || rr_out_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_rr_out: valid=%b data=%h, required 0/0000", rr_out_valid, rr_out_data);
        end
        checks++;
        if (s4_in_ready !== 4'b0 || s5_in_ready !== 5'b0 || rr_in_ready !== 4'b0) begin
            errors++;
            $display("FAIL reset_in_ready: s4=%b s5=%b rr=%b, required all zero", s4_in_ready, s5_in_ready, rr_in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rr_in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_rr_first_grant: in_ready=%b, required 0001", rr_in_ready);
        end
    endtask

    task automatic test_rr_all();
        logic [3:0] exp_rdy;
        int         exp_src;
        for (int k = 0; k < 8; k++) begin
            exp_src = k % 4;
            exp_rdy = 4'(1 << exp_src);
            #1;
            checks++;
            if (rr_in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_all_ready[%0d]: in_ready=%b, required %b", k, rr_in_ready, exp_rdy);
            end
            step();
            checks++;
            if (rr_out_src !== 2'(exp_src) || rr_out_valid !== 1'b1 || rr_out_data !== 16'(16'h1000 + exp_src)) begin
                errors++;
                $display("FAIL rr_all_out[%0d]: src=%0d valid=%b data=%h, required %0d/1/%h",
                         k, rr_out_src, rr_out_valid, rr_out_data, exp_src, 16'(16'h1000 + exp_src));
            end
        end
    endtask

    task automatic test_rr_sparse();
        int gs [3] = '{1, 3, 1};
        do_reset();
        rr_in_valid  = 4'b1010;
        rr_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (rr_in_ready !== 4'(1 << gs[k]) || (rr_in_ready & 4'b0101) !== 4'b0) begin
                errors++;
                $display("FAIL rr_sparse_ready[%0d]: in_ready=%b, required %b", k, rr_in_ready, 4'(1 << gs[k]));
            end
            step();
            checks++;
            if (rr_out_src !== 2'(gs[k]) || rr_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_sparse_src[%0d]: src=%0d valid=%b, required %0d/1", k, rr_out_src, rr_out_valid, gs[k]);
            end
        end
    endtask

    task automatic test_sel();
        s4_out_ready = 1'b1;
        s4_sel       = 2'd2;
        s4_in_data   = 64'h0;
        s4_in_data[47:32] = 16'hA5A5;
        s4_in_valid  = 4'b0100;
        #1;
        checks++;
        if (s4_in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL sel2_ready: in_ready=%b, required 0100", s4_in_ready);
        end
        step();
        checks++;
        if (s4_out_data !== 16'hA5A5 || s4_out_src !== 2'd2 || s4_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sel2_out: data=%h src=%0d valid=%b, required a5a5/2/1", s4_out_data, s4_out_src, s4_out_valid);
        end
        s4_sel = 2'd1;
        s4_in_data[31:16] = 16'h5A5A;
        s4_in_valid = 4'b0010;
        #1;
        checks++;
        if (s4_in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL sel1_ready: in_ready=%b, required 0010", s4_in_ready);
        end
        step();
        checks++;
        if (s4_out_data !== 16'h5A5A || s4_out_src !== 2'd1 || s4_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sel1_out: data=%h src=%0d valid=%b, required 5a5a/1/1", s4_out_data, s4_out_src, s4_out_valid);
        end

        s5_out_ready = 1'b1;
        s5_in_valid  = 5'h1F;
        s5_in_data   = 80'h4444_3333_2222_1111_0000;
        s5_sel       = 3'd4;
        step();
        checks++;
        if (s5_out_data !== 16'h4444 || s5_out_src !== 3'd4 || s5_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sel4_n5_out: data=%h src=%0d valid=%b, required 4444/4/1", s5_out_data, s5_out_src, s5_out_valid);
        end
        s5_sel = 3'd5;
        #1;
        checks++;
        if (s5_in_ready !== 5'b0) begin
            errors++;
            $display("FAIL sel5_ready: in_ready=%b, required 00000", s5_in_ready);
        end
        step();
        checks++;
        if (s5_out_valid !== 1'b0 || s5_out_data !== 16'h4444 || s5_out_src !== 3'd4) begin
            errors++;
            $display("FAIL sel5_out: valid=%b data=%h src=%0d, required 0/4444/4", s5_out_valid, s5_out_data, s5_out_src);
        end
        s5_sel = 3'd7;
        #1;
        checks++;
        if (s5_in_ready !== 5'b0) begin
            errors++;
            $display("FAIL sel7_ready: in_ready=%b, required 00000", s5_in_ready);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        s4_sel = 2'd0;
        s4_in_data = 64'h0;
        s4_in_data[15:0] = 16'h1234;
        s4_in_valid  = 4'b0001;
        s4_out_ready = 1'b1;
        rr_in_valid  = 4'hF;
        rr_in_data   = 64'h1003_1002_1001_1000;
        rr_out_ready = 1'b1;
        step();
        s4_in_data[15:0] = 16'h5678;
        s4_out_ready = 1'b0;
        rr_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (s4_in_ready !== 4'b0 || rr_in_ready !== 4'b0) begin
                errors++;
                $display("FAIL stall_ready[%0d]: s4=%b rr=%b, required 0000", k, s4_in_ready, rr_in_ready);
            end
            step();
            checks++;
            if (s4_out_data !== 16'h1234 || s4_out_valid !== 1'b1 || rr_out_src !== 2'd0 || rr_out_data !== 16'h1000) begin
                errors++;
                $display("FAIL stall_hold[%0d]: s4 data=%h valid=%b rr src=%0d data=%h, required 1234/1/0/1000",
                         k, s4_out_data, s4_out_valid, rr_out_src, rr_out_data);
            end
        end
        s4_out_ready = 1'b1;
        rr_out_ready = 1'b1;
        #1;
        checks++;
        if (s4_in_ready !== 4'b0001 || rr_in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL release_ready: s4=%b rr=%b, required 0001/0010", s4_in_ready, rr_in_ready);
        end
        step();
        checks++;
        if (s4_out_data !== 16'h5678 || s4_out_valid !== 1'b1 || rr_out_src !== 2'd1 || rr_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL release_out: s4 data=%h valid=%b rr src=%0d valid=%b, required 5678/1/1/1",
                     s4_out_data, s4_out_valid, rr_out_src, rr_out_valid);
        end
        // idle cycle without requests must not move the pointer
        rr_in_valid = 4'b0;
        step();
        rr_in_valid = 4'hF;
        #1;
        checks++;
        if (rr_in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL idle_ptr_ready: in_ready=%b, required 0100", rr_in_ready);
        end
    endtask

    task automatic test_midstall_reset();
        rr_in_valid  = 4'b0100;
        rr_out_ready = 1'b1;
        step();
        rr_out_ready = 1'b0;
        rr_in_valid  = 4'hF;
        step();
        checks++;
        if (rr_out_valid !== 1'b1 || rr_out_src !== 2'd2) begin
            errors++;
            $display("FAIL midstall_pre: valid=%b src=%0d, required 1/2", rr_out_valid, rr_out_src);
        end
        rst = 1'b1;
        step();
        checks++;
        if (rr_out_valid !== 1'b0 || rr_out_data !== 16'h0 || rr_out_src !== 2'd0) begin
            errors++;
            $display("FAIL midstall_reset: valid=%b data=%h src=%0d, required 0/0000/0", rr_out_valid, rr_out_data, rr_out_src);
        end
        rst = 1'b0;
        rr_out_ready = 1'b1;
        #1;
        checks++;
        if (rr_in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midstall_ptr: in_ready=%b, required 0001", rr_in_ready);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        s4_in_data = '0; s4_in_valid = '0; s4_sel = '0; s4_out_ready = 1'b0;
        s5_in_data = '0; s5_in_valid = '0; s5_sel = '0; s5_out_ready = 1'b0;
        rr_in_data = '0; rr_in_valid = '0; rr_sel = '0; rr_out_ready = 1'b0;
        test_reset();
        test_rr_all();
        test_rr_sparse();
        test_sel();
        test_backpressure();
        test_midstall_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
